// File: rtl/sdram_bus_bridge.sv
// sdram_bus_bridge
//   Bridges the PicoRV32 native memory bus (mem_valid/mem_ready) to the SDRAM
//   controller request port. Each request is registered and held stable until
//   the controller's ready pulse. Byte strobes become DQM masks. ram_init is
//   pulsed after reset. A timeout completes a request whose ready never
//   arrives, returning 32'hDEAD_BEEF and setting a sticky error flag.
//
//   Optional feature macro: SDRAM_CACHE_EN
//     Adds a direct-mapped, write-through read cache of CACHE_LINES words.
//
// Ports
//   clk          system clock, shared with the SDRAM controller
//   resetn       asynchronous active-low reset
//   mem_valid    CPU request (already address-decoded)
//   mem_addr     CPU byte address; bits [24:2] used
//   mem_wdata    CPU write data
//   mem_wstrb    CPU byte strobes; 4'b0000 means read
//   mem_ready    one-clock completion pulse
//   mem_rdata    read data; holds its last value between accesses
//   ram_init     controller init request, high after reset
//   ram_addr     word-aligned controller address
//   ram_we       controller write request
//   ram_oe       controller read request
//   ram_dqm      byte masks (~wstrb on writes, 0 on reads)
//   ram_din      controller write data
//   ram_dout     controller read data
//   ram_ready    controller completion, high for two clocks
//   timeout_err  sticky timeout flag, cleared only by reset

module sdram_bus_bridge #(
  parameter int INIT_CYCLES    = 64,
  parameter int TIMEOUT_CYCLES = 128,
  parameter int CACHE_LINES    = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        ram_init,
  output logic [24:0] ram_addr,
  output logic        ram_we,
  output logic        ram_oe,
  output logic [3:0]  ram_dqm,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  input  logic        ram_ready,
  output logic        timeout_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t state, state_next;

  logic [7:0]      init_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            ready_q;
  logic            ready_rise;
  logic            init_last;
  logic            timeout_hit;
  logic            cache_rd_hit;
  logic [31:0]     cache_rdata;
  logic            unused_ok;

  // The controller holds ready for two clocks; only its first clock counts.
  assign ready_rise  = ram_ready & ~ready_q;
  assign init_last   = (init_cnt == 8'(INIT_CYCLES - 1));
  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign mem_ready   = (state == S_DONE);
  assign unused_ok   = &{1'b0, mem_addr[31:25], mem_addr[1:0], (CACHE_LINES > 0)};

`ifdef SDRAM_CACHE_EN
  localparam int IW  = $clog2(CACHE_LINES);
  localparam int TGW = 23 - IW;

  logic [31:0]      cache_data [CACHE_LINES];
  logic [TGW-1:0]   cache_tag  [CACHE_LINES];
  logic [CACHE_LINES-1:0] cache_valid;

  logic [IW-1:0]  in_idx, req_idx;
  logic [TGW-1:0] in_tag, req_tag;
  logic           req_hit, fill, write_upd;

  assign in_idx  = mem_addr[IW+1:2];
  assign in_tag  = mem_addr[24:IW+2];
  assign req_idx = ram_addr[IW+1:2];
  assign req_tag = ram_addr[24:IW+2];

  assign cache_rd_hit = (mem_wstrb == 4'b0000) && cache_valid[in_idx] &&
                        (cache_tag[in_idx] == in_tag);
  assign cache_rdata  = cache_data[in_idx];
  assign req_hit      = cache_valid[req_idx] && (cache_tag[req_idx] == req_tag);

  // Only accesses completed by a real ready edge touch the cache, so a
  // timed-out read never fills a line.
  assign fill      = (state == S_WAIT) && ready_rise && ram_oe;
  assign write_upd = (state == S_WAIT) && ready_rise && ram_we && req_hit;

  always_ff @(posedge clk) begin
    if (fill) begin
      cache_data[req_idx] <= ram_dout;
      cache_tag[req_idx]  <= req_tag;
    end else if (write_upd) begin
      for (int b = 0; b < 4; b++) begin
        if (!ram_dqm[b]) cache_data[req_idx][8*b +: 8] <= ram_din[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cache_valid <= '0;
    end else if (fill) begin
      cache_valid[req_idx] <= 1'b1;
    end
  end
`else
  assign cache_rd_hit = 1'b0;
  assign cache_rdata  = 32'h0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_INIT;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_INIT:  if (init_last) state_next = S_IDLE;
      S_IDLE:  if (mem_valid) state_next = cache_rd_hit ? S_DONE : S_WAIT;
      S_WAIT:  if (ready_rise || timeout_hit) state_next = S_DONE;
      S_DONE:  state_next = S_DRAIN;
      S_DRAIN: if (!ram_ready) state_next = S_IDLE;
      default: state_next = S_INIT;
    endcase
  end

  // Request registers, counters and returned data. Request strobes are
  // cleared on the same edge that recognises completion, so ram_we/ram_oe
  // are only ever high while the FSM sits in WAIT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      init_cnt    <= '0;
      to_cnt      <= '0;
      ready_q     <= 1'b0;
      ram_init    <= 1'b1;
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_oe      <= 1'b0;
      ram_dqm     <= '0;
      ram_din     <= '0;
      mem_rdata   <= '0;
      timeout_err <= 1'b0;
    end else begin
      ready_q <= ram_ready;
      case (state)
        S_INIT: begin
          if (init_last) ram_init <= 1'b0;
          else           init_cnt <= init_cnt + 8'd1;
        end
        S_IDLE: begin
          if (mem_valid) begin
            if (cache_rd_hit) begin
              mem_rdata <= cache_rdata;
            end else begin
              ram_addr <= {mem_addr[24:2], 2'b00};
              ram_din  <= mem_wdata;
              ram_dqm  <= (|mem_wstrb) ? ~mem_wstrb : 4'b0000;
              ram_we   <= |mem_wstrb;
              ram_oe   <= ~|mem_wstrb;
              to_cnt   <= '0;
            end
          end
        end
        S_WAIT: begin
          if (ready_rise) begin
            if (ram_oe) mem_rdata <= ram_dout;
            ram_we <= 1'b0;
            ram_oe <= 1'b0;
          end else if (timeout_hit) begin
            mem_rdata   <= 32'hDEAD_BEEF;
            timeout_err <= 1'b1;
            ram_we      <= 1'b0;
            ram_oe      <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_bus_bridge.sv
// tb_sdram_bus_bridge
//   Self-checking bench for sdram_bus_bridge. A behavioural SDRAM controller
//   model answers requests with a two-clock ready pulse; expected read data is
//   queued when a request is issued and popped by a monitor on each mem_ready.

module tb_sdram_bus_bridge;

  localparam int INIT_CYCLES    = 8;
  localparam int TIMEOUT_CYCLES = 40;
  localparam int CACHE_LINES    = 16;
  localparam int MODEL_LAT      = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        ram_init;
  logic [24:0] ram_addr;
  logic        ram_we;
  logic        ram_oe;
  logic [3:0]  ram_dqm;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        ram_ready;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mem_model [bit [24:0]];

  logic        model_en;
  int          req_count;
  int          ready_pulses;
  int          mr_count;
  logic [24:0] seen_addr;
  logic        seen_we, seen_oe;
  logic [3:0]  seen_dqm, start_dqm;
  logic [31:0] seen_din, start_din;

  sdram_bus_bridge #(
    .INIT_CYCLES   (INIT_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CACHE_LINES   (CACHE_LINES)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .ram_init   (ram_init),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_oe     (ram_oe),
    .ram_dqm    (ram_dqm),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .ram_ready  (ram_ready),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one access now and wait for mem_ready; cycles counts clock edges
  // from issue to the edge that raised mem_ready.
  task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                                input bit hold, output int cycles);
    exp_q.push_back(exp_rdata);
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    mem_valid = 1'b1;
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!mem_ready && cycles < 200);
    if (!mem_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL mem_ready_wait: got no mem_ready expected one within 200 clocks");
    end
    if (!hold) mem_valid = 1'b0;
  endtask

  // Hold reset, check reset values, release, and measure the ram_init pulse.
  task automatic reset_and_init();
    int n;
    logic any_req;
    resetn = 1'b0;
    idle(3);
    check_output("rst_ram_init", {31'b0, ram_init}, 32'd1);
    check_output("rst_mem_ready", {31'b0, mem_ready}, 32'd0);
    check_output("rst_we_oe", {30'b0, ram_we, ram_oe}, 32'd0);
    check_output("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
    check_output("rst_mem_rdata", mem_rdata, 32'd0);
    resetn = 1'b1;
    n = 0;
    any_req = 1'b0;
    @(negedge clk);
    while (ram_init && n < 1000) begin
      n++;
      any_req |= ram_we | ram_oe | mem_ready;
      @(negedge clk);
    end
    check_output("init_cycles", n, INIT_CYCLES);
    idle(4);
    any_req |= ram_we | ram_oe | mem_ready;
    check_output("init_no_request", {31'b0, any_req}, 32'd0);
  endtask

  // Behavioural SDRAM controller: fixed latency, ready high for two clocks.
  initial begin
    ram_ready = 1'b0;
    ram_dout  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (model_en && resetn && (ram_we || ram_oe)) begin
        req_count++;
        start_din = ram_din;
        start_dqm = ram_dqm;
        repeat (MODEL_LAT) @(posedge clk);
        #1;
        seen_addr = ram_addr;
        seen_we   = ram_we;
        seen_oe   = ram_oe;
        seen_dqm  = ram_dqm;
        seen_din  = ram_din;
        if (ram_oe) ram_dout = mem_model.exists(ram_addr) ? mem_model[ram_addr] : 32'h0;
        if (ram_we) begin
          logic [31:0] w;
          w = mem_model.exists(ram_addr) ? mem_model[ram_addr] : 32'h0;
          for (int b = 0; b < 4; b++) begin
            if (!ram_dqm[b]) w[8*b +: 8] = ram_din[8*b +: 8];
          end
          mem_model[ram_addr] = w;
        end
        ram_ready = 1'b1;
        ready_pulses++;
        @(posedge clk);
        @(posedge clk);
        #1;
        ram_ready = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every mem_ready consumes one queued expectation.
  always @(negedge clk) begin
    if (resetn) begin
      check_output("we_oe_exclusive", {31'b0, ram_we & ram_oe}, 32'd0);
      if (mem_ready) begin
        mr_count++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_mem_ready: got pulse expected none");
        end else begin
          check_output("rdata", mem_rdata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc, p0, m0, r0;
    resetn       = 1'b0;
    mem_valid    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wstrb    = '0;
    model_en     = 1'b1;
    req_count    = 0;
    ready_pulses = 0;
    mr_count     = 0;
    mem_model[25'h0001004] = 32'h1234_5678;
    mem_model[25'h0002000] = 32'h1122_3344;
    mem_model[25'h1002004] = 32'h5A5A_C3C3;
    mem_model[25'h0000040] = 32'hCAFE_F00D;

    $display("[TB] reset and init");
    reset_and_init();

    $display("[TB] single read");
    apply_stimulus(32'h0000_1004, 32'h0, 4'b0000, 32'h1234_5678, 1'b0, cyc);
    check_output("read_latency", cyc, MODEL_LAT + 2);
    check_output("read_addr", {7'b0, seen_addr}, 32'h0001004);
    check_output("read_dqm", {28'b0, seen_dqm}, 32'h0);
    check_output("read_we_oe", {30'b0, seen_we, seen_oe}, 32'd1);
    idle(3);

    $display("[TB] masked write then read back");
    apply_stimulus(32'h0000_2000, 32'hAABB_CCDD, 4'b0101, 32'h1234_5678, 1'b0, cyc);
    check_output("write_we_oe", {30'b0, seen_we, seen_oe}, 32'd2);
    check_output("write_dqm", {28'b0, seen_dqm}, 32'hA);
    check_output("write_din_start", start_din, 32'hAABB_CCDD);
    check_output("write_din_held", seen_din, 32'hAABB_CCDD);
    check_output("write_dqm_start", {28'b0, start_dqm}, 32'hA);
    idle(3);
    apply_stimulus(32'h0000_2000, 32'h0, 4'b0000, 32'h11BB_33DD, 1'b0, cyc);
    idle(3);
    apply_stimulus(32'h0100_2007, 32'h0, 4'b0000, 32'h5A5A_C3C3, 1'b0, cyc);
    check_output("addr_mask", {7'b0, seen_addr}, 32'h1002004);
    idle(3);

    $display("[TB] timeout");
    check_output("timeout_err_clear", {31'b0, timeout_err}, 32'd0);
    model_en = 1'b0;
    apply_stimulus(32'h0000_3000, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b0, cyc);
    check_output("timeout_latency", cyc, TIMEOUT_CYCLES + 1);
    check_output("timeout_err_set", {31'b0, timeout_err}, 32'd1);
    idle(3);
    check_output("timeout_we_oe_drop", {30'b0, ram_we, ram_oe}, 32'd0);

    $display("[TB] reset during access");
    mem_addr  = 32'h0000_1004;
    mem_wstrb = 4'b0000;
    mem_valid = 1'b1;
    idle(3);
    check_output("midreset_oe_before", {31'b0, ram_oe}, 32'd1);
    resetn = 1'b0;
    #1;
    check_output("midreset_oe_after", {31'b0, ram_oe}, 32'd0);
    check_output("midreset_init", {31'b0, ram_init}, 32'd1);
    check_output("midreset_err_clear", {31'b0, timeout_err}, 32'd0);
    mem_valid = 1'b0;
    reset_and_init();
    model_en = 1'b1;

    $display("[TB] back-to-back reads");
    p0 = ready_pulses;
    m0 = mr_count;
    apply_stimulus(32'h0000_1004, 32'h0, 4'b0000, 32'h1234_5678, 1'b1, cyc);
    apply_stimulus(32'h0000_2000, 32'h0, 4'b0000, 32'h11BB_33DD, 1'b1, cyc);
    apply_stimulus(32'h0100_2007, 32'h0, 4'b0000, 32'h5A5A_C3C3, 1'b0, cyc);
    idle(3);
    check_output("b2b_ready_pulses", ready_pulses - p0, 32'd3);
    check_output("b2b_mem_ready", mr_count - m0, 32'd3);

`ifdef SDRAM_CACHE_EN
    $display("[TB] read cache");
    r0 = req_count;
    apply_stimulus(32'h0000_0040, 32'h0, 4'b0000, 32'hCAFE_F00D, 1'b0, cyc);
    check_output("cache_miss_latency", cyc, MODEL_LAT + 2);
    check_output("cache_miss_req", req_count - r0, 32'd1);
    idle(3);
    apply_stimulus(32'h0000_0040, 32'h0, 4'b0000, 32'hCAFE_F00D, 1'b0, cyc);
    check_output("cache_hit_latency", cyc, 32'd1);
    check_output("cache_hit_no_req", req_count - r0, 32'd1);
    idle(3);
    apply_stimulus(32'h0000_0040, 32'h0000_0099, 4'b0001, 32'hCAFE_F00D, 1'b0, cyc);
    check_output("cache_write_req", req_count - r0, 32'd2);
    idle(3);
    apply_stimulus(32'h0000_0040, 32'h0, 4'b0000, 32'hCAFE_F099, 1'b0, cyc);
    check_output("cache_update_latency", cyc, 32'd1);
    idle(3);
`else
    r0 = req_count;
`endif

    idle(5);
    check_output("pending_expect", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
